// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: forwarding select codes, hazard FSM encodings and default register index width
package fwd_hazard_unit_pkg;
  localparam int REG_AW_DEF = 5;
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EXM = 2'b01;
  localparam fwd_sel_t FWD_MWB = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LU    = 2'd1;
  localparam logic [1:0] ST_MWAIT = 2'd2;
endpackage

// File: rtl/fwd_hazard_unit_fwd_match.sv
// fwd_match: does a tracked pipeline entry produce the register a decode source reads
//   i_v, i_we, i_rd : tracked entry (valid, writes rd, destination index)
//   i_rs, i_use     : decode source index and whether the instruction reads it
//   o_hit           : entry is a live writer of that source (x0 never matches)
module fwd_match #(
  parameter int REG_AW = 5
) (
  input  logic              i_v,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_use,
  output logic              o_hit
);
  assign o_hit = i_v & i_we & (i_rd != '0) & (i_rs == i_rd) & i_use;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks EX/MEM/WB destinations, registers EX operand forward selects, raises decode stall
//   i_clk, i_rstn            : clock, asynchronous active-low reset
//   i_id_*                   : decode slot (valid, sources + use flags, rd, we, is_load)
//   i_mem_ready              : 0 freezes the whole pipeline
//   i_flush                  : redirect, kills the decode slot
//   o_stall                  : hold PC/IF/ID this cycle
//   o_fwd_a, o_fwd_b         : registered EX operand selects
//   o_stall_cnt              : saturating stall-cycle count
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_we,
  input  logic              i_id_is_load,
  input  logic              i_mem_ready,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic [CNT_W-1:0]  o_stall_cnt
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } ent_t;
  // index 0 = EX, 1 = MEM, 2 = WB
  ent_t [2:0]       ent_q, ent_d;
  ent_t             new_e;
  fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic             hazard, inject;
  fwd_match #(.REG_AW(REG_AW)) u_ex_a (
    .i_v(ent_q[0].v), .i_we(ent_q[0].we), .i_rd(ent_q[0].rd),
    .i_rs(i_id_rs1), .i_use(i_id_use_rs1), .o_hit(hit_ex_a)
  );
  fwd_match #(.REG_AW(REG_AW)) u_ex_b (
    .i_v(ent_q[0].v), .i_we(ent_q[0].we), .i_rd(ent_q[0].rd),
    .i_rs(i_id_rs2), .i_use(i_id_use_rs2), .o_hit(hit_ex_b)
  );
  fwd_match #(.REG_AW(REG_AW)) u_mem_a (
    .i_v(ent_q[1].v), .i_we(ent_q[1].we), .i_rd(ent_q[1].rd),
    .i_rs(i_id_rs1), .i_use(i_id_use_rs1), .o_hit(hit_mem_a)
  );
  fwd_match #(.REG_AW(REG_AW)) u_mem_b (
    .i_v(ent_q[1].v), .i_we(ent_q[1].we), .i_rd(ent_q[1].rd),
    .i_rs(i_id_rs2), .i_use(i_id_use_rs2), .o_hit(hit_mem_b)
  );
  always_comb begin
    hazard  = ent_q[0].ld & (hit_ex_a | hit_ex_b);
    inject  = i_id_valid & ~hazard & ~i_flush;
    o_stall = ~i_mem_ready | (hazard & ~i_flush);
    new_e   = inject ? {1'b1, i_id_rd, i_id_we, i_id_is_load} : '0;
    ent_d   = i_mem_ready ? {ent_q[1:0], new_e} : ent_q;
    // the current EX entry becomes EX/MEM as the new instruction enters EX, so it is the newer producer
    fwd_a_d = ~i_mem_ready ? fwd_a_q : ~inject ? FWD_RF :
              hit_ex_a ? FWD_EXM : hit_mem_a ? FWD_MWB : FWD_RF;
    fwd_b_d = ~i_mem_ready ? fwd_b_q : ~inject ? FWD_RF :
              hit_ex_b ? FWD_EXM : hit_mem_b ? FWD_MWB : FWD_RF;
    st_d    = ~i_mem_ready ? ST_MWAIT : (st_q == ST_RUN && hazard) ? ST_LU : ST_RUN;
    cnt_d   = (o_stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ent_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      st_q    <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_fwd_a     = fwd_a_q;
  assign o_fwd_b     = fwd_b_q;
  assign o_stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenarios for forwarding selects, load-use stall, flush, memory wait and reset
module tb_fwd_hazard_unit;
  import fwd_hazard_unit_pkg::*;
  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_id_valid, i_id_use_rs1, i_id_use_rs2, i_id_we, i_id_is_load;
  logic [4:0]  i_id_rs1, i_id_rs2, i_id_rd;
  logic        i_mem_ready, i_flush;
  logic        o_stall;
  logic [1:0]  o_fwd_a, o_fwd_b;
  logic [31:0] o_stall_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 0;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_id_valid(i_id_valid),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_id_rd(i_id_rd), .i_id_we(i_id_we), .i_id_is_load(i_id_is_load),
    .i_mem_ready(i_mem_ready), .i_flush(i_flush), .o_stall(o_stall),
    .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0; i_id_use_rs1 = 0; i_id_use_rs2 = 0;
    i_id_rd = 0; i_id_we = 0; i_id_is_load = 0; i_flush = 0;
  endtask

  task automatic present(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic we, input logic ld);
    i_id_valid = 1; i_id_rd = rd; i_id_rs1 = rs1; i_id_use_rs1 = u1;
    i_id_rs2 = rs2; i_id_use_rs2 = u2; i_id_we = we; i_id_is_load = ld;
  endtask

  task automatic test_reset();
    idle();
    i_mem_ready = 1;
    i_rstn = 0;
    #3;
    n_vec++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL reset_fwd_a: got %b want 00", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL reset_fwd_b: got %b want 00", o_fwd_b); end
    n_vec++; if (o_stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", o_stall_cnt); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", o_stall); end
    tick();
    tick();
    i_rstn = 1;
    tick();
  endtask

  task automatic test_exm();
    present(5, 0, 0, 0, 0, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL exm_stall0: got %b want 0", o_stall); end
    tick();
    present(6, 5, 1, 5, 1, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL exm_stall1: got %b want 0", o_stall); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b01) begin n_err++; $display("FAIL exm_fwd_a: got %b want 01", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b01) begin n_err++; $display("FAIL exm_fwd_b: got %b want 01", o_fwd_b); end
    idle();
  endtask

  task automatic test_mwb();
    present(5, 0, 0, 0, 0, 1, 0);
    tick();
    present(0, 0, 0, 0, 0, 1, 0);
    tick();
    present(7, 5, 1, 1, 1, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL mwb_stall: got %b want 0", o_stall); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b10) begin n_err++; $display("FAIL mwb_fwd_a: got %b want 10", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL mwb_fwd_b: got %b want 00", o_fwd_b); end
    idle();
  endtask

  task automatic test_x0_we0();
    present(0, 0, 0, 0, 0, 1, 0);
    tick();
    present(3, 0, 1, 0, 1, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b want 0", o_stall); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL x0_fwd_a: got %b want 00", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL x0_fwd_b: got %b want 00", o_fwd_b); end
    present(9, 0, 0, 0, 0, 0, 1);
    tick();
    present(4, 9, 1, 9, 1, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL we0_stall: got %b want 0", o_stall); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL we0_fwd_a: got %b want 00", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL we0_fwd_b: got %b want 00", o_fwd_b); end
    idle();
  endtask

  task automatic test_load_use();
    present(5, 2, 1, 0, 0, 1, 1);
    tick();
    present(6, 5, 1, 0, 1, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", o_stall); end
    tick();
    exp_cnt++;
    n_vec++; if (dut.st_q !== ST_LU) begin n_err++; $display("FAIL lu_state: got %0d want %0d", dut.st_q, ST_LU); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_end: got %b want 0", o_stall); end
    n_vec++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL lu_bubble_fwd_a: got %b want 00", o_fwd_a); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b10) begin n_err++; $display("FAIL lu_fwd_a: got %b want 10", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL lu_fwd_b: got %b want 00", o_fwd_b); end
    n_vec++; if (o_stall_cnt !== exp_cnt) begin n_err++; $display("FAIL lu_cnt: got %0d want %0d", o_stall_cnt, exp_cnt); end
    n_vec++; if (dut.st_q !== ST_RUN) begin n_err++; $display("FAIL lu_state_run: got %0d want %0d", dut.st_q, ST_RUN); end
    idle();
  endtask

  task automatic test_flush();
    tick();
    tick();
    present(5, 0, 0, 0, 0, 1, 1);
    tick();
    present(6, 5, 1, 5, 1, 1, 0);
    i_flush = 1;
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", o_stall); end
    tick();
    idle();
    present(7, 6, 1, 0, 0, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall_next: got %b want 0", o_stall); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL flush_bubble_fwd_a: got %b want 00", o_fwd_a); end
    n_vec++; if (o_stall_cnt !== exp_cnt) begin n_err++; $display("FAIL flush_cnt: got %0d want %0d", o_stall_cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      present(5'(10 + p), 0, 0, 0, 0, 1, 1);
      tick();
      present(5'(20 + p), 5'(10 + p), 1, 0, 0, 1, 0);
      #1;
      n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall%0d: got %b want 1", p, o_stall); end
      tick();
      exp_cnt++;
      n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall_end%0d: got %b want 0", p, o_stall); end
      tick();
      n_vec++; if (o_fwd_a !== 2'b10) begin n_err++; $display("FAIL b2b_fwd_a%0d: got %b want 10", p, o_fwd_a); end
      n_vec++; if (o_stall_cnt !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt%0d: got %0d want %0d", p, o_stall_cnt, exp_cnt); end
    end
    idle();
  endtask

  task automatic test_mem_wait();
    i_rstn = 0;
    #1;
    i_rstn = 1;
    exp_cnt = 0;
    present(5, 0, 0, 0, 0, 1, 0);
    tick();
    present(5, 5, 1, 0, 0, 1, 0);
    tick();
    n_vec++; if (o_fwd_a !== 2'b01) begin n_err++; $display("FAIL mw_pre_fwd_a: got %b want 01", o_fwd_a); end
    present(6, 5, 1, 5, 1, 1, 0);
    i_mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL mw_stall%0d: got %b want 1", i, o_stall); end
      n_vec++; if (o_fwd_a !== 2'b01) begin n_err++; $display("FAIL mw_hold_a%0d: got %b want 01", i, o_fwd_a); end
      n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL mw_hold_b%0d: got %b want 00", i, o_fwd_b); end
      tick();
      exp_cnt++;
    end
    i_mem_ready = 1;
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL mw_release_stall: got %b want 0", o_stall); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b01) begin n_err++; $display("FAIL mw_fwd_a: got %b want 01", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b01) begin n_err++; $display("FAIL mw_fwd_b: got %b want 01", o_fwd_b); end
    n_vec++; if (o_stall_cnt !== exp_cnt) begin n_err++; $display("FAIL mw_cnt: got %0d want %0d", o_stall_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    present(7, 6, 1, 0, 0, 1, 0);
    tick();
    n_vec++; if (o_fwd_a !== 2'b01) begin n_err++; $display("FAIL rm_pre_fwd_a: got %b want 01", o_fwd_a); end
    #2;
    i_rstn = 0;
    #1;
    n_vec++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL rm_fwd_a: got %b want 00", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL rm_fwd_b: got %b want 00", o_fwd_b); end
    n_vec++; if (o_stall_cnt !== 32'd0) begin n_err++; $display("FAIL rm_cnt: got %0d want 0", o_stall_cnt); end
    tick();
    i_rstn = 1;
    present(8, 6, 1, 7, 1, 1, 0);
    #1;
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rm_post_stall: got %b want 0", o_stall); end
    tick();
    n_vec++; if (o_fwd_a !== 2'b00) begin n_err++; $display("FAIL rm_post_fwd_a: got %b want 00", o_fwd_a); end
    n_vec++; if (o_fwd_b !== 2'b00) begin n_err++; $display("FAIL rm_post_fwd_b: got %b want 00", o_fwd_b); end
    idle();
  endtask

  initial begin
    test_reset();
    test_exm();
    test_mwb();
    test_x0_we0();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_mem_wait();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
